data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder (memory) end of the pipeline CPU's data-memory port: serves loads and stores issued on mem_addr/mem_byte_slct/data_to_write_mem/mem_we/mem_re.
- Replaces the zero-latency combinational RAM model with a wait-stated, single-read-port word array, a one-entry posted store buffer with byte-merge forwarding, and a stall request back to the CPU.
- Sits beside the instruction ROM in the SOPC; the CPU holds its request stable while stall_req is high.

Parameters:
- Depth, 1024, number of 32-bit words in the array.
- AddrBits, 10, log2(Depth); word index = addr_i[AddrBits+1:2].
- ReadWait, 2, wait cycles per load (0..15); 0 = same-cycle data.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- ce  input  1  read request (CPU mem_re).
- we  input  1  write request (CPU mem_we).
- addr_i  input  `MemAddrWidth (32)  byte address; bits [1:0] ignored.
- byte_slct  input  4  write byte enables; bit i enables data_i[8i+7:8i].
- data_i  input  `RegDataWidth (32)  store data.
- data_o  output  `RegDataWidth (32)  load data, full word; the CPU's RM_ctrl extracts bytes.
- stall_req  output  1  high while a load is waiting; CPU freezes its pipeline.
- err  output  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset (rst=0, async): FSM to IDLE, wait counter 0, store buffer invalid, err 0, stall_req 0, data_o 0. Array contents are not reset. A buffered store pending at reset is discarded. Reset mid-WAIT aborts the load.
- Range check: word index >= Depth is out of range. Writes are dropped; reads return 0 with no wait; err is high for one cycle, registered (the cycle after the request).
- Store, cycle T (we=1 and in range): {index, byte_slct, data_i} is captured into the buffer at the end of T.
  - The buffer writes its enabled bytes into the array at the end of T+1, so stores are posted and never stall.
  - A new store in T+1 drains the old entry and captures the new one in the same edge.
  - byte_slct=0 stores nothing but still counts as a store.
- we and ce both high: treated as a store only, no stall.
- Load forwarding: if the buffer is valid with the same index, data_o takes buffered bytes where the buffer's byte_slct=1 and array bytes elsewhere.
- Load FSM (ce=1, we=0), states IDLE and WAIT:
  - ReadWait=0: data_o is combinational in the request cycle; stall_req 0; stays in IDLE.
  - ReadWait=N>0, request accepted in IDLE at cycle T: stall_req=1 combinationally in T..T+N-1; state is WAIT with a counter counting down from N-1.
  - In cycle T+N: stall_req=0, data_o valid, return to IDLE. The next load is a new request with its own N-cycle wait.
  - ce dropping in WAIT: abort to IDLE, stall_req 0 next cycle.
  - addr_i change in WAIT: protocol violation; the sampled index from T is used.
- data_o holds its last load value when no load is valid. stall_req is never asserted for stores.

Decomposition:
- Into define.v (the shared header), as `defines: FSM state encodings (`DmIdle, `DmWait), `DmDepthDefault, `DmReadWaitDefault. Data and address widths come from the existing `RegDataWidth and `MemAddrWidth.
- One sub-module, dm_store_buf: the valid/index/byte-enable/data register, drain write-enable, and byte-merge forwarding mux.
- data_mem_responder keeps the FSM, counter, range check, and array.

Test Plan:
- Reset, then rst=1 with idle inputs -> data_o=0, stall_req=0, err=0; with ReadWait=0, a load of word 0 after a store shows the stored value.
- ReadWait=2: store 0xDEADBEEF at 0x10 (slct 4'hF); three idle cycles; load 0x10 at T -> stall_req high for T and T+1, low at T+2 with data_o=0xDEADBEEF.
- Forwarding: store 0x11223344 at 0x20 at T; store 0x000000AA slct 4'b0001 at 0x20 at T+1; load 0x20 at T+2 -> final data_o=0x112233AA.
- Back-to-back stores at 0x0/0x4/0x8 (values 1/2/3), then loads -> 1, 2, 3, each with a ReadWait stall.
- Out of range: Depth=1024, load at 0x1000 -> data_o=0, no stall, err one-cycle pulse; store there -> later load at 0x0 unchanged.
- Abort and reset: drop ce in the first WAIT cycle -> stall_req 0 next cycle. Assert rst=0 in the middle of a WAIT and with a store pending -> outputs 0 immediately; the pending store is absent from the array.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared types, defaults and byte-merge helper for the data-memory responder
package data_mem_responder_pkg;

    typedef enum logic {
        DM_IDLE = 1'b0,
        DM_WAIT = 1'b1
    } dm_state_e;

    localparam int DM_DEPTH_DEFAULT     = 1024;
    localparam int DM_READ_WAIT_DEFAULT = 2;
    localparam int REG_DATA_WIDTH       = 32;
    localparam int MEM_ADDR_WIDTH       = 32;

    // Take bytes from new_word where be is set, otherwise from old_word.
    function automatic logic [REG_DATA_WIDTH-1:0] merge_bytes(
        input logic [3:0]                be,
        input logic [REG_DATA_WIDTH-1:0] new_word,
        input logic [REG_DATA_WIDTH-1:0] old_word
    );
        logic [REG_DATA_WIDTH-1:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_responder_dm_store_buf.sv
// rtl/data_mem_responder_dm_store_buf.sv - one-entry posted store buffer with drain and byte-merge forwarding
module dm_store_buf
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cap_en,
    input  logic [ADDR_BITS-1:0]      cap_idx,
    input  logic [3:0]                cap_be,
    input  logic [REG_DATA_WIDTH-1:0] cap_data,
    input  logic [ADDR_BITS-1:0]      fwd_idx,
    input  logic [REG_DATA_WIDTH-1:0] arr_word,
    output logic                      drain_we,
    output logic [ADDR_BITS-1:0]      drain_idx,
    output logic [3:0]                drain_be,
    output logic [REG_DATA_WIDTH-1:0] drain_data,
    output logic [REG_DATA_WIDTH-1:0] fwd_word
);

    logic                      valid_q;
    logic [ADDR_BITS-1:0]      idx_q;
    logic [3:0]                be_q;
    logic [REG_DATA_WIDTH-1:0] data_q;

    // An entry lives exactly one cycle: it drains on the edge after capture,
    // and a new capture on that same edge refills the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= cap_en;
            if (cap_en) begin
                idx_q  <= cap_idx;
                be_q   <= cap_be;
                data_q <= cap_data;
            end
        end
    end

    assign drain_we   = valid_q;
    assign drain_idx  = idx_q;
    assign drain_be   = be_q;
    assign drain_data = data_q;

    always_comb begin
        fwd_word = arr_word;
        if (valid_q && (idx_q == fwd_idx)) begin
            fwd_word = merge_bytes(be_q, data_q, arr_word);
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated data-memory responder with posted store buffer and CPU stall request
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH     = DM_DEPTH_DEFAULT,
    parameter int ADDR_BITS = 10,
    parameter int READ_WAIT = DM_READ_WAIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      we,
    input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]                byte_slct,
    input  logic [REG_DATA_WIDTH-1:0] data_i,
    output logic [REG_DATA_WIDTH-1:0] data_o,
    output logic                      stall_req,
    output logic                      err
);

    logic [REG_DATA_WIDTH-1:0] mem_array [DEPTH];

    dm_state_e                 state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]      idx_q, idx_d;
    logic [REG_DATA_WIDTH-1:0] data_q;
    logic                      err_q;

    logic [MEM_ADDR_WIDTH-1:0] word_full;
    logic                      in_range;
    logic [ADDR_BITS-1:0]      req_idx;
    logic [ADDR_BITS-1:0]      rd_idx;
    logic                      load_req;
    logic                      store_req;
    logic                      stall;
    logic                      deliver;
    logic                      deliver_zero;
    logic [REG_DATA_WIDTH-1:0] arr_word;
    logic [REG_DATA_WIDTH-1:0] fwd_word;
    logic                      drain_we;
    logic [ADDR_BITS-1:0]      drain_idx;
    logic [3:0]                drain_be;
    logic [REG_DATA_WIDTH-1:0] drain_data;
    logic                      unused_addr_lsb;

    assign unused_addr_lsb = ^addr_i[1:0];

    // Range check uses the full word index so high addresses never alias low words.
    assign word_full = {2'b00, addr_i[MEM_ADDR_WIDTH-1:2]};
    assign in_range  = (word_full < MEM_ADDR_WIDTH'(DEPTH));
    assign req_idx   = addr_i[ADDR_BITS+1:2];
    assign load_req  = ce && !we;
    assign store_req = we && in_range;
    assign rd_idx    = (state_q == DM_WAIT) ? idx_q : req_idx;
    assign arr_word  = mem_array[rd_idx];

    dm_store_buf #(
        .ADDR_BITS (ADDR_BITS)
    ) u_store_buf (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (store_req),
        .cap_idx    (req_idx),
        .cap_be     (byte_slct),
        .cap_data   (data_i),
        .fwd_idx    (rd_idx),
        .arr_word   (arr_word),
        .drain_we   (drain_we),
        .drain_idx  (drain_idx),
        .drain_be   (drain_be),
        .drain_data (drain_data),
        .fwd_word   (fwd_word)
    );

    always_ff @(posedge clk) begin
        if (drain_we) begin
            for (int b = 0; b < 4; b++) begin
                if (drain_be[b]) begin
                    mem_array[drain_idx][8*b +: 8] <= drain_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        stall        = 1'b0;
        deliver      = 1'b0;
        deliver_zero = 1'b0;
        case (state_q)
            DM_IDLE: begin
                if (load_req) begin
                    if (!in_range) begin
                        deliver_zero = 1'b1;
                    end else if (READ_WAIT == 0) begin
                        deliver = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = DM_WAIT;
                        cnt_d   = 4'(READ_WAIT - 1);
                        idx_d   = req_idx;
                    end
                end
            end
            DM_WAIT: begin
                // Withdrawing the request (or turning it into a store) abandons the load.
                if (!load_req) begin
                    state_d = DM_IDLE;
                end else if (cnt_q == 4'd0) begin
                    deliver = 1'b1;
                    state_d = DM_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DM_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (deliver) begin
                data_q <= fwd_word;
            end else if (deliver_zero) begin
                data_q <= '0;
            end
            err_q <= (we || (ce && (state_q == DM_IDLE))) && !in_range;
        end
    end

    // Outputs are forced low while reset is held, even with a request on the inputs.
    always_comb begin
        data_o = data_q;
        if (!rst || deliver_zero) begin
            data_o = '0;
        end else if (deliver) begin
            data_o = fwd_word;
        end
    end

    assign stall_req = rst && stall;
    assign err       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst, ce, we;
    logic [31:0] addr, din;
    logic [3:0]  slct;
    logic [31:0] d2, d0;
    logic        st2, st0, er2, er0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .ADDR_BITS(10), .READ_WAIT(2)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr_i(addr), .byte_slct(slct),
        .data_i(din), .data_o(d2), .stall_req(st2), .err(er2)
    );

    data_mem_responder #(.DEPTH(1024), .ADDR_BITS(10), .READ_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr_i(addr), .byte_slct(slct),
        .data_i(din), .data_o(d0), .stall_req(st0), .err(er0)
    );

    // Apply one cycle of inputs just after the edge, then settle at the falling edge.
    task automatic step_in(input logic c, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
        @(posedge clk);
        #1;
        ce = c; we = w; addr = a; slct = s; din = d;
        @(negedge clk);
    endtask

    // Issue a load to the wait-stated instance and hold it until stall drops.
    task automatic load_wait(input string name, input logic [31:0] a, input logic [31:0] exp);
        int n;
        n = 0;
        step_in(1, 0, a, 4'h0, 32'h0);
        checks++;
        if (st2 !== 1'b1) begin failures++; $display("FAIL %s_stall_first got=%b exp=1", name, st2); end
        while (st2 === 1'b1 && n < 8) begin
            step_in(1, 0, a, 4'h0, 32'h0);
            n++;
        end
        checks++;
        if (n != 2) begin failures++; $display("FAIL %s_wait_cycles got=%0d exp=2", name, n); end
        checks++;
        if (d2 !== exp) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, d2, exp); end
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 0; we = 0; addr = 0; slct = 0; din = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (d2 !== 32'h0 || st2 !== 1'b0 || er2 !== 1'b0) begin
            failures++; $display("FAIL reset_state data=%h stall=%b err=%b exp=0/0/0", d2, st2, er2);
        end
        checks++;
        if (d0 !== 32'h0 || st0 !== 1'b0 || er0 !== 1'b0) begin
            failures++; $display("FAIL reset_state_rw0 data=%h stall=%b err=%b exp=0/0/0", d0, st0, er0);
        end
    endtask

    task automatic test_rw0();
        step_in(0, 1, 32'h0, 4'hF, 32'hCAFEF00D);
        step_in(1, 0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (d0 !== 32'hCAFEF00D) begin failures++; $display("FAIL rw0_fwd_data got=%h exp=cafef00d", d0); end
        checks++;
        if (st0 !== 1'b0) begin failures++; $display("FAIL rw0_no_stall got=%b exp=0", st0); end
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (d0 !== 32'hCAFEF00D) begin failures++; $display("FAIL rw0_hold got=%h exp=cafef00d", d0); end
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_wait();
        step_in(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        checks++;
        if (st2 !== 1'b0) begin failures++; $display("FAIL store_no_stall got=%b exp=0", st2); end
        repeat (3) step_in(0, 0, 32'h0, 4'h0, 32'h0);
        load_wait("wait_load", 32'h10, 32'hDEADBEEF);
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (d2 !== 32'hDEADBEEF || st2 !== 1'b0) begin
            failures++; $display("FAIL wait_hold data=%h stall=%b exp=deadbeef/0", d2, st2);
        end
    endtask

    task automatic test_forward();
        step_in(0, 1, 32'h20, 4'hF, 32'h11223344);
        step_in(0, 1, 32'h20, 4'b0001, 32'h000000AA);
        step_in(1, 0, 32'h20, 4'h0, 32'h0);
        checks++;
        if (d0 !== 32'h112233AA) begin failures++; $display("FAIL fwd_merge_rw0 got=%h exp=112233aa", d0); end
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
        load_wait("fwd_load", 32'h20, 32'h112233AA);
    endtask

    task automatic test_back_to_back();
        step_in(0, 1, 32'h0, 4'hF, 32'h1);
        step_in(0, 1, 32'h4, 4'hF, 32'h2);
        step_in(0, 1, 32'h8, 4'hF, 32'h3);
        load_wait("b2b_0", 32'h0, 32'h1);
        load_wait("b2b_4", 32'h4, 32'h2);
        load_wait("b2b_8", 32'h8, 32'h3);
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_out_of_range();
        step_in(1, 0, 32'h1000, 4'h0, 32'h0);
        checks++;
        if (d2 !== 32'h0 || st2 !== 1'b0 || er2 !== 1'b0) begin
            failures++; $display("FAIL oor_load data=%h stall=%b err=%b exp=0/0/0", d2, st2, er2);
        end
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (er2 !== 1'b1 || d2 !== 32'h0) begin failures++; $display("FAIL oor_err_pulse err=%b data=%h exp=1/0", er2, d2); end
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (er2 !== 1'b0) begin failures++; $display("FAIL oor_err_clear got=%b exp=0", er2); end
        step_in(0, 1, 32'h1000, 4'hF, 32'hFFFFFFFF);
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (er2 !== 1'b1) begin failures++; $display("FAIL oor_store_err got=%b exp=1", er2); end
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
        load_wait("oor_word0", 32'h0, 32'h1);
        checks++;
        if (d0 !== 32'h1) begin failures++; $display("FAIL oor_word0_rw0 got=%h exp=1", d0); end
    endtask

    task automatic test_abort();
        step_in(1, 0, 32'h4, 4'h0, 32'h0);
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (st2 !== 1'b0 || d2 !== 32'h1) begin
            failures++; $display("FAIL abort_idle stall=%b data=%h exp=0/1", st2, d2);
        end
        load_wait("after_abort", 32'h8, 32'h3);
    endtask

    task automatic test_reset_mid();
        step_in(0, 1, 32'h14, 4'hF, 32'h0BADF00D);
        repeat (2) step_in(0, 0, 32'h0, 4'h0, 32'h0);
        step_in(1, 0, 32'h8, 4'h0, 32'h0);
        step_in(1, 0, 32'h8, 4'h0, 32'h0);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (st2 !== 1'b0 || d2 !== 32'h0 || er2 !== 1'b0 || d0 !== 32'h0) begin
            failures++; $display("FAIL reset_mid_wait stall=%b data=%h err=%b data0=%h exp=0", st2, d2, er2, d0);
        end
        ce = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        step_in(0, 1, 32'h14, 4'hF, 32'h00000055);
        @(posedge clk);
        #1 rst = 1'b0; ce = 0; we = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step_in(0, 0, 32'h0, 4'h0, 32'h0);
        load_wait("reset_drop_store", 32'h14, 32'h0BADF00D);
        checks++;
        if (d0 !== 32'h0BADF00D) begin failures++; $display("FAIL reset_drop_store_rw0 got=%h exp=0badf00d", d0); end
    endtask

    initial begin
        test_reset();
        test_rw0();
        test_wait();
        test_forward();
        test_back_to_back();
        test_out_of_range();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
